// File: rtl/picomips_step_ctrl.sv
// picomips_step_ctrl
//   Run/step controller for the picoMIPS board demo. Generates a one-cycle
//   CPU enable pulse (tick) in one of four modes: HALT, RUN at a selectable
//   rate, debounced single STEP, or FAST (every cycle).
// Ports
//   fastclk     in   system clock, rising edge
//   nReset      in   asynchronous active-low reset
//   mode        in   [1:0] 00 HALT, 01 RUN, 10 STEP, 11 FAST (raw switches)
//   rate_sel    in   [1:0] RUN period = max(1, BASE_DIV >> (2*rate_sel))
//   step_btn    in   raw, bouncy, active-high push-button
//   tick        out  CPU enable pulse, one fastclk cycle wide
//   running     out  effective mode is RUN or FAST
//   tick_count  out  [CNT_W-1:0] ticks issued since reset, wrapping
module picomips_step_ctrl #(
   parameter int unsigned BASE_DIV  = 5_000_000,
   parameter int unsigned DIV_W     = 23,
   parameter int unsigned DB_CYCLES = 500_000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             fastclk,
   input  logic             nReset,
   input  logic [1:0]       mode,
   input  logic [1:0]       rate_sel,
   input  logic             step_btn,
   output logic             tick,
   output logic             running,
   output logic [CNT_W-1:0] tick_count
);

   localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
   localparam int unsigned P0 = ((BASE_DIV >> 0) == 0) ? 1 : (BASE_DIV >> 0);
   localparam int unsigned P1 = ((BASE_DIV >> 2) == 0) ? 1 : (BASE_DIV >> 2);
   localparam int unsigned P2 = ((BASE_DIV >> 4) == 0) ? 1 : (BASE_DIV >> 4);
   localparam int unsigned P3 = ((BASE_DIV >> 6) == 0) ? 1 : (BASE_DIV >> 6);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_FAST = 2'b11
   } state_t;

   logic [1:0]       r_mode_s1, r_mode_s2;
   logic [1:0]       r_rate_s1, r_rate_s2;
   logic             r_btn_s1, r_btn_s2;
   logic [1:0]       r_rate;
   logic             r_db_level, r_db_level_d;
   logic [DB_W-1:0]  r_db_cnt;
   logic [DIV_W-1:0] r_div;
   state_t           r_state;
   logic             r_tick, r_running;
   logic [CNT_W-1:0] r_tick_count;

   state_t           w_state_next;
   logic             w_changed;
   logic             w_step_req;
   logic             w_tick_next;
   logic             w_running_next;
   logic [DIV_W-1:0] w_div_next;
   logic [DIV_W-1:0] w_period_m1;

   // Input synchronisers and debouncer
   always_ff @(posedge fastclk or negedge nReset) begin
      if (!nReset) begin
         r_mode_s1    <= '0;
         r_mode_s2    <= '0;
         r_rate_s1    <= '0;
         r_rate_s2    <= '0;
         r_btn_s1     <= 1'b0;
         r_btn_s2     <= 1'b0;
         r_db_level   <= 1'b0;
         r_db_level_d <= 1'b0;
         r_db_cnt     <= '0;
      end else begin
         r_mode_s1    <= mode;
         r_mode_s2    <= r_mode_s1;
         r_rate_s1    <= rate_sel;
         r_rate_s2    <= r_rate_s1;
         r_btn_s1     <= step_btn;
         r_btn_s2     <= r_btn_s1;
         r_db_level_d <= r_db_level;
         // Level flips only after DB_CYCLES consecutive mismatching cycles
         if (r_btn_s2 != r_db_level) begin
            if (r_db_cnt == DB_W'(DB_CYCLES - 1)) begin
               r_db_level <= r_btn_s2;
               r_db_cnt   <= '0;
            end else begin
               r_db_cnt   <= r_db_cnt + DB_W'(1);
            end
         end else begin
            r_db_cnt <= '0;
         end
      end
   end

   assign w_step_req = r_db_level & ~r_db_level_d;

   always_comb begin
      unique case (r_rate)
         2'd0:    w_period_m1 = DIV_W'(P0 - 1);
         2'd1:    w_period_m1 = DIV_W'(P1 - 1);
         2'd2:    w_period_m1 = DIV_W'(P2 - 1);
         default: w_period_m1 = DIV_W'(P3 - 1);
      endcase
   end

   // FSM state register: state tracks the synced mode one cycle later
   always_ff @(posedge fastclk or negedge nReset) begin
      if (!nReset) begin
         r_state <= S_HALT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and output logic. A change of synced mode or rate clears the
   // divider and suppresses any pending tick, including a step_req in flight.
   always_comb begin
      w_state_next   = state_t'(r_mode_s2);
      w_changed      = (w_state_next != r_state) || (r_rate_s2 != r_rate);
      w_div_next     = '0;
      w_tick_next    = 1'b0;
      if (!w_changed) begin
         unique case (r_state)
            S_RUN: begin
               if (r_div == w_period_m1) begin
                  w_tick_next = 1'b1;
               end else begin
                  w_div_next = r_div + DIV_W'(1);
               end
            end
            S_STEP:  w_tick_next = w_step_req;
            S_FAST:  w_tick_next = 1'b1;
            default: w_tick_next = 1'b0;
         endcase
      end
      w_running_next = (w_state_next == S_RUN) || (w_state_next == S_FAST);
   end

   always_ff @(posedge fastclk or negedge nReset) begin
      if (!nReset) begin
         r_rate       <= '0;
         r_div        <= '0;
         r_tick       <= 1'b0;
         r_running    <= 1'b0;
         r_tick_count <= '0;
      end else begin
         r_rate       <= r_rate_s2;
         r_div        <= w_div_next;
         r_tick       <= w_tick_next;
         r_running    <= w_running_next;
         r_tick_count <= r_tick_count + CNT_W'(w_tick_next);
      end
   end

   assign tick       = r_tick;
   assign running    = r_running;
   assign tick_count = r_tick_count;

endmodule
